chunked_subtractor: RTL

Multi-cycle ripple-borrow subtractor that computes A − B − borrow_in over WIDTH bits, CHUNK bits per clock, with valid/ready handshakes on both sides. It complements the combinational ripple-carry adders in the arithmetic library. It is the subtraction datapath for sequential ALU and accumulator blocks, where a long combinational borrow chain would limit clock frequency.

---
 rtl/chunked_subtractor_if.sv | 26 ++
 rtl/chunked_subtractor.sv | 117 +++++++++++
 2 files changed

// File: rtl/chunked_subtractor_if.sv
// Handshake bus for chunked_subtractor: operand request side and result response side.
interface chunked_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, A, B, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow, zero
    );

    modport slave (
        input  in_valid, A, B, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow, zero
    );
endinterface

// File: rtl/chunked_subtractor.sv
// Multi-cycle ripple-borrow subtractor: A - B - borrow_in, CHUNK bits per clock.
// The borrow between chunks is carried in a register, so the critical path is one CHUNK-bit ripple.
module chunked_sub_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module chunked_subtractor #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    chunked_subtractor_if.slave bus
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic              in_ready, out_valid, accept, release_res, last;
    logic [WIDTH-1:0]  a_r, b_r, diff_r, diff_nxt;
    logic [IW-1:0]     idx;
    logic              bw_r, bo_r, ov_r, z_r;
    logic [CHUNK-1:0]  a_c, b_c, d_c;
    logic [CHUNK:0]    bw;

    assign accept      = bus.in_valid && in_ready;
    assign release_res = out_valid && bus.out_ready;
    assign last        = (idx == LAST);

    // Current chunk through a CHUNK-bit ripple of full subtractors
    assign a_c   = a_r[idx*CHUNK +: CHUNK];
    assign b_c   = b_r[idx*CHUNK +: CHUNK];
    assign bw[0] = bw_r;

    for (genvar k = 0; k < CHUNK; k++) begin : g_bit
        chunked_sub_bit u_bit (
            .a    (a_c[k]),
            .b    (b_c[k]),
            .bin  (bw[k]),
            .d    (d_c[k]),
            .bout (bw[k+1])
        );
    end

    always_comb begin
        diff_nxt = diff_r;
        diff_nxt[idx*CHUNK +: CHUNK] = d_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)      state_nxt = BUSY;
            BUSY:    if (last)        state_nxt = DONE;
            DONE:    if (release_res) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) && !rst;
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            bw_r   <= 1'b0;
            idx    <= '0;
            diff_r <= '0;
            bo_r   <= 1'b0;
            ov_r   <= 1'b0;
            z_r    <= 1'b0;
        end else begin
            if (accept) begin
                a_r  <= bus.A;
                b_r  <= bus.B;
                bw_r <= bus.borrow_in;
                idx  <= '0;
            end
            if (state == BUSY) begin
                diff_r <= diff_nxt;
                bw_r   <= bw[CHUNK];
                idx    <= idx + 1'b1;
                // Flags only change on the final chunk so they stay stable through DONE
                if (last) begin
                    bo_r <= bw[CHUNK];
                    ov_r <= bw[CHUNK-1] ^ bw[CHUNK];
                    z_r  <= (diff_nxt == '0);
                end
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.diff       = diff_r;
    assign bus.borrow_out = bo_r;
    assign bus.overflow   = ov_r;
    assign bus.zero       = z_r;
endmodule
